wave_analyzer: RTL

//  Consumer-side monitor for the oscillator sample streams (triangle and similar up/down waves).

---
 rtl/wave_pkg.sv | 14 +
 rtl/wave_analyzer_period_meter.sv | 56 +++++
 rtl/wave_analyzer.sv | 115 +++++++++++
 3 files changed

// File: rtl/wave_pkg.sv
// Shared analyzer/generator types for the oscillator sample-stream blocks.
package wave_pkg;

    typedef enum logic [1:0] {
        AN_IDLE,
        AN_PRIMED,
        AN_RISING,
        AN_FALLING
    } analyzer_state_t;

    localparam int WAVE_N_DEFAULT = 8;
    localparam int WAVE_P_DEFAULT = 16;

endpackage

// File: rtl/wave_analyzer_period_meter.sv
// Trough-to-trough period meter: saturating sample counter, period capture and lock detect.
module period_meter #(
    parameter int P = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         ena,
    input  logic         trough_hit,
    output logic [P-1:0] period_out,
    output logic         period_valid,
    output logic         locked
);

    localparam logic [P-1:0] CNT_MAX = '1;
    localparam logic [P-1:0] CNT_ONE = {{(P-1){1'b0}}, 1'b1};

    logic [P-1:0] r_cnt;
    logic [P-1:0] r_prev_period;
    logic         r_have_trough;
    logic [P-1:0] w_cnt_next;

    assign w_cnt_next = (r_cnt == CNT_MAX) ? r_cnt : r_cnt + CNT_ONE;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt         <= '0;
            r_prev_period <= '0;
            r_have_trough <= 1'b0;
            period_out    <= '0;
            period_valid  <= 1'b0;
            locked        <= 1'b0;
        end else begin
            period_valid <= 1'b0;
            if (ena) begin
                if (trough_hit) begin
                    // r_cnt is never 0 here, so the zero reset of r_prev_period cannot fake a lock.
                    if (r_have_trough) begin
                        period_out    <= r_cnt;
                        period_valid  <= 1'b1;
                        locked        <= (r_cnt == r_prev_period) &&
                                         (r_cnt != CNT_MAX) && (r_prev_period != CNT_MAX);
                        r_prev_period <= r_cnt;
                    end
                    r_cnt         <= CNT_ONE;
                    r_have_trough <= 1'b1;
                end else begin
                    r_cnt <= w_cnt_next;
                    if (w_cnt_next == CNT_MAX) begin
                        locked <= 1'b0;
                    end
                end
            end
        end
    end

endmodule

// File: rtl/wave_analyzer.sv
// Up/down wave monitor: slope FSM, peak/trough capture and trough period measurement.
// Optional step check enabled by defining WAVE_ANALYZER_STEP_CHECK_EN.
module wave_analyzer
    import wave_pkg::*;
#(
    parameter int N = WAVE_N_DEFAULT,
    parameter int P = WAVE_P_DEFAULT
`ifdef WAVE_ANALYZER_STEP_CHECK_EN
    ,
    parameter int MAX_STEP = 1
`endif
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         ena,
    input  logic [N-1:0] in,
    output logic         dir,
    output logic [N-1:0] peak_out,
    output logic [N-1:0] trough_out,
    output logic         peak_stb,
    output logic         trough_stb,
    output logic [P-1:0] period_out,
    output logic         period_valid,
    output logic         locked
`ifdef WAVE_ANALYZER_STEP_CHECK_EN
    ,
    output logic         step_err
`endif
);

    analyzer_state_t r_state;
    logic [N-1:0]    r_prev;
    logic            w_trough_hit;

    assign w_trough_hit = ena && (r_state == AN_FALLING) && (in > r_prev);

`ifdef WAVE_ANALYZER_STEP_CHECK_EN
    localparam logic [N:0] STEP_LIMIT = (N+1)'(MAX_STEP);

    logic [N:0] w_step_diff;
    logic [N:0] w_step_mag;

    assign w_step_diff = {1'b0, in} - {1'b0, r_prev};
    assign w_step_mag  = w_step_diff[N] ? (~w_step_diff + 1'b1) : w_step_diff;

    always_ff @(posedge clk) begin
        if (rst) begin
            step_err <= 1'b0;
        end else begin
            step_err <= ena && (r_state != AN_IDLE) && (w_step_mag > STEP_LIMIT);
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= AN_IDLE;
            r_prev     <= '0;
            dir        <= 1'b0;
            peak_out   <= '0;
            trough_out <= '0;
            peak_stb   <= 1'b0;
            trough_stb <= 1'b0;
        end else begin
            // NOTE: strobes default low every cycle so they can only last one clock.
            peak_stb   <= 1'b0;
            trough_stb <= 1'b0;
            if (ena) begin
                r_prev <= in;
                case (r_state)
                    AN_IDLE: r_state <= AN_PRIMED;
                    AN_PRIMED: begin
                        if (in > r_prev) begin
                            r_state <= AN_RISING;
                            dir     <= 1'b0;
                        end else if (in < r_prev) begin
                            r_state <= AN_FALLING;
                            dir     <= 1'b1;
                        end
                    end
                    AN_RISING: begin
                        if (in < r_prev) begin
                            peak_out <= r_prev;
                            peak_stb <= 1'b1;
                            r_state  <= AN_FALLING;
                            dir      <= 1'b1;
                        end
                    end
                    AN_FALLING: begin
                        if (in > r_prev) begin
                            trough_out <= r_prev;
                            trough_stb <= 1'b1;
                            r_state    <= AN_RISING;
                            dir        <= 1'b0;
                        end
                    end
                    default: r_state <= AN_IDLE;
                endcase
            end
        end
    end

    period_meter #(
        .P (P)
    ) u_period_meter (
        .clk          (clk),
        .rst          (rst),
        .ena          (ena),
        .trough_hit   (w_trough_hit),
        .period_out   (period_out),
        .period_valid (period_valid),
        .locked       (locked)
    );

endmodule
